cpu_mem_sequencer: RTL and testbench

//  Parametrised fetch/load-store sequencer for the multi-cycle CPU: owns the PC and instruction register.

---
 rtl/cpu_mem_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_mem_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_sequencer.sv
// cpu_mem_sequencer
//   Fetch / load-store sequencer for the multi-cycle CPU. Owns the PC and the
//   instruction register and drives a single memory port through a req/ack
//   handshake, so the memory behind it may take any number of cycles.
//
// Ports
//   clk            clock, rising edge
//   reset          synchronous, active-low reset
//   mem_req        memory request, held until acknowledged
//   mem_we         1 = write, 0 = read (valid with mem_req)
//   mem_addr       memory address (valid with mem_req)
//   mem_wdata      write data (valid with mem_req & mem_we)
//   mem_rdata      read data, sampled on the ack cycle
//   mem_ack        memory completes the current request this cycle
//   retire         core finished the instruction; advance the PC
//   branch_en      with retire: load branch_target instead of PC+PC_STEP
//   branch_target  branch destination
//   ls_req         load/store request for the current instruction
//   ls_we          1 = store, 0 = load
//   ls_addr        load/store address
//   ls_wdata       store data
//   pc             address of the instruction held in instr
//   instr          instruction register
//   instr_valid    one-cycle pulse when a new instruction is latched
//   ls_rdata       load data register
//   ls_done        one-cycle pulse when a load/store completes
//   bus_err        sticky memory timeout flag
//   state          current state (FETCH=0, EXEC=1, LSU=2, HALT=3)

module cpu_mem_sequencer #(
  parameter int unsigned        ADDR_W       = 16,
  parameter int unsigned        DATA_W       = 16,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int unsigned        PC_STEP      = 1,
  parameter int unsigned        TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              retire,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic              bus_err,
  output logic [2:0]        state
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_LSU   = 3'd2,
    ST_HALT  = 3'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                instr_valid_q, instr_valid_d;
  logic                ls_done_q, ls_done_d;
  logic                bus_err_q, bus_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   pc_next;
  logic                timeout_hit;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    ls_rdata_d    = ls_rdata_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    instr_valid_d = 1'b0;
    ls_done_d     = 1'b0;
    bus_err_d     = bus_err_q;
    cnt_d         = cnt_q;
    pc_next       = pc_q;
    // The current cycle is the TIMEOUT-th unacknowledged request cycle.
    timeout_hit   = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

    unique case (state_q)
      ST_FETCH: begin
        if (!mem_req_q) begin
          // Only reached straight after reset; later fetches are launched
          // from EXEC so that a zero-wait fetch costs a single FETCH cycle.
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
          cnt_d      = '0;
        end else if (mem_ack) begin
          instr_d       = mem_rdata;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = ST_EXEC;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_EXEC: begin
        if (ls_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          cnt_d       = '0;
          state_d     = ST_LSU;
        end else if (retire) begin
          pc_next    = branch_en ? branch_target : pc_q + ADDR_W'(PC_STEP);
          pc_d       = pc_next;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_next;
          cnt_d      = '0;
          state_d    = ST_FETCH;
        end
      end

      ST_LSU: begin
        if (mem_ack) begin
          if (!mem_we_q) begin
            ls_rdata_d = mem_rdata;
          end
          ls_done_d = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_EXEC;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HALT: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        bus_err_d = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      ls_rdata_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      instr_valid_q <= 1'b0;
      ls_done_q     <= 1'b0;
      bus_err_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      ls_rdata_q    <= ls_rdata_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      instr_valid_q <= instr_valid_d;
      ls_done_q     <= ls_done_d;
      bus_err_q     <= bus_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign ls_rdata    = ls_rdata_q;
  assign ls_done     = ls_done_q;
  assign bus_err     = bus_err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Scoreboard bench for cpu_mem_sequencer: a core-side stimulus process pushes
// expected memory requests and completion events; a monitor pops and compares
// them as the DUT presents them; a memory responder acks with variable delay.

module tb_cpu_mem_sequencer;

  logic        clk;
  logic        reset;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        retire, branch_en, ls_req, ls_we;
  logic [15:0] branch_target, ls_addr, ls_wdata;
  logic [15:0] pc, instr, ls_rdata;
  logic        instr_valid, ls_done, bus_err;
  logic [2:0]  state;

  cpu_mem_sequencer #(
    .ADDR_W(16), .DATA_W(16), .RESET_VECTOR(16'h0000), .PC_STEP(1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .retire(retire), .branch_en(branch_en), .branch_target(branch_target),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .ls_rdata(ls_rdata),
    .ls_done(ls_done), .bus_err(bus_err), .state(state)
  );

  typedef struct packed { logic we; logic [15:0] addr; logic [15:0] wdata; } req_t;
  typedef struct packed { logic is_ls; logic [15:0] pc; logic [15:0] instr; logic [15:0] rdata; } evt_t;

  req_t req_q[$];
  evt_t evt_q[$];
  logic [15:0] env_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  int total = 0;
  int bad   = 0;
  int unsigned ack_delay = 0;
  bit no_ack = 1'b0;

  logic [15:0] m_pc, m_instr, m_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 16'hA5A5;
  endfunction

  // Memory responder: acks after ack_delay extra cycles, garbage otherwise,
  // and occasionally pulses ack while no request is pending.
  initial begin
    int unsigned wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req && !no_ack && wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          env_mem[mem_addr] = mem_wdata;
          mem_rdata = 16'($urandom);
        end else begin
          mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : (mem_addr ^ 16'hA5A5);
        end
        wcnt = 0;
      end else begin
        mem_rdata = 16'($urandom);
        if (mem_req) begin
          mem_ack = 1'b0;
          wcnt++;
        end else begin
          mem_ack = ($urandom_range(0, 3) == 0);
          wcnt = 0;
        end
      end
    end
  end

  // Monitor
  logic        p_req, p_acc, p_we, p_iv;
  logic [15:0] p_addr, p_wdata;
  req_t        er;
  evt_t        ee;

  always @(negedge clk) begin
    if (!reset) begin
      p_req = 1'b0; p_acc = 1'b0; p_iv = 1'b0;
    end else begin
      if (mem_req && !p_req) begin
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected: got addr=%h we=%b, expected no request", mem_addr, mem_we);
        end else begin
          er = req_q.pop_front();
          chk("req_addr", 32'(mem_addr), 32'(er.addr));
          chk("req_we", 32'(mem_we), 32'(er.we));
          if (er.we) chk("req_wdata", 32'(mem_wdata), 32'(er.wdata));
        end
      end
      if (mem_req && p_req && !p_acc) begin
        chk("hold_addr", 32'(mem_addr), 32'(p_addr));
        chk("hold_we", 32'(mem_we), 32'(p_we));
        chk("hold_wdata", 32'(mem_wdata), 32'(p_wdata));
      end
      if (p_acc) chk("req_drop", 32'(mem_req), 32'd0);
      if (instr_valid || ls_done) begin
        if (evt_q.size() == 0) begin
          total++; bad++;
          $display("FAIL evt_unexpected: got instr_valid=%b ls_done=%b, expected none", instr_valid, ls_done);
        end else begin
          ee = evt_q.pop_front();
          chk("evt_kind", {30'd0, ls_done, instr_valid}, ee.is_ls ? 32'd2 : 32'd1);
          chk("evt_pc", 32'(pc), 32'(ee.pc));
          chk("evt_instr", 32'(instr), 32'(ee.instr));
          chk("evt_ls_rdata", 32'(ls_rdata), 32'(ee.rdata));
          chk("evt_state", 32'(state), 32'd1);
          if (instr_valid) chk("iv_pulse", 32'(p_iv), 32'd0);
        end
      end
      p_req   = mem_req;
      p_acc   = mem_req && mem_ack;
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wdata = mem_wdata;
      p_iv    = instr_valid;
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid || ls_done) return;
    end
    total++; bad++;
    $display("FAIL wait_done: got no instr_valid/ls_done, expected one within 40 cycles");
  endtask

  // Called at a negedge with reset held low; releases reset and expects the first fetch.
  task automatic start_after_reset();
    chk("queues_empty", 32'(req_q.size() + evt_q.size()), 32'd0);
    req_q.delete();
    evt_q.delete();
    m_pc = 16'h0000;
    m_rdata = 16'h0000;
    m_instr = ref_rd(m_pc);
    req_q.push_back('{we: 1'b0, addr: m_pc, wdata: 16'h0});
    evt_q.push_back('{is_ls: 1'b0, pc: m_pc, instr: m_instr, rdata: m_rdata});
    reset = 1'b1;
    wait_done();
  endtask

  task automatic op_retire(input logic br, input logic [15:0] tgt);
    m_pc = br ? tgt : m_pc + 16'd1;
    m_instr = ref_rd(m_pc);
    req_q.push_back('{we: 1'b0, addr: m_pc, wdata: 16'h0});
    evt_q.push_back('{is_ls: 1'b0, pc: m_pc, instr: m_instr, rdata: m_rdata});
    retire = 1'b1; branch_en = br; branch_target = tgt;
    @(negedge clk);
    retire = 1'b0; branch_en = 1'b0;
    wait_done();
  endtask

  task automatic op_ls(input logic we, input logic [15:0] a, input logic [15:0] d, input logic with_retire);
    req_q.push_back('{we: we, addr: a, wdata: d});
    if (we) ref_mem[a] = d;
    else m_rdata = ref_rd(a);
    evt_q.push_back('{is_ls: 1'b1, pc: m_pc, instr: m_instr, rdata: m_rdata});
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d;
    retire = with_retire; branch_en = with_retire; branch_target = 16'h7777;
    @(negedge clk);
    ls_req = 1'b0; retire = 1'b0; branch_en = 1'b0;
    wait_done();
  endtask

  initial begin
    int unsigned cnt;
    int unsigned r;
    logic [15:0] tgt;
    reset = 1'b0;
    retire = 0; branch_en = 0; branch_target = '0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    m_pc = '0; m_instr = '0; m_rdata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_ls_rdata", 32'(ls_rdata), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_ls_done", 32'(ls_done), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);

    // 1: zero-wait first fetch
    ack_delay = 0;
    start_after_reset();
    chk("t1_instr", 32'(instr), 32'h0000A5A5);
    chk("t1_state", 32'(state), 32'd1);
    @(negedge clk);
    chk("t1_iv_low", 32'(instr_valid), 32'd0);

    // 2: slow memory, sequential retire
    ack_delay = 3;
    op_retire(1'b0, 16'h0);
    chk("t2_pc", 32'(pc), 32'd1);

    // 3: load, store, load-back, ls_req+retire collision
    ack_delay = 1;
    env_mem[16'h0040] = 16'h1234;
    ref_mem[16'h0040] = 16'h1234;
    op_ls(1'b0, 16'h0040, 16'h0, 1'b0);
    chk("t3_load", 32'(ls_rdata), 32'h00001234);
    op_ls(1'b1, 16'h0044, 16'hBEEF, 1'b0);
    chk("t3_store_hold", 32'(ls_rdata), 32'h00001234);
    op_ls(1'b0, 16'h0044, 16'h0, 1'b0);
    chk("t3_loadback", 32'(ls_rdata), 32'h0000BEEF);
    op_ls(1'b0, 16'h0041, 16'h0, 1'b1);
    chk("t3_pc_kept", 32'(pc), 32'd1);

    // 4: branch and PC wrap
    ack_delay = 0;
    op_retire(1'b1, 16'h0100);
    chk("t4_branch", 32'(pc), 32'h00000100);
    op_retire(1'b1, 16'hFFFF);
    op_retire(1'b0, 16'h0);
    chk("t4_wrap", 32'(pc), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      ack_delay = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = $urandom_range(0, 9);
      tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      if (r <= 2)      op_retire(1'b0, 16'h0);
      else if (r == 3) op_retire(1'b1, tgt);
      else if (r <= 5) op_ls(1'b0, 16'h0040 + 16'($urandom_range(0, 15)), 16'($urandom), 1'b0);
      else if (r <= 7) op_ls(1'b1, 16'h0040 + 16'($urandom_range(0, 15)), 16'($urandom), 1'b0);
      else             op_ls(r[0], 16'h0040 + 16'($urandom_range(0, 15)), 16'($urandom), 1'b1);
    end

    // 5: timeout with no ack
    no_ack = 1'b1;
    m_pc = m_pc + 16'd1;
    req_q.push_back('{we: 1'b0, addr: m_pc, wdata: 16'h0});
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (!mem_req) break;
      cnt++;
      @(negedge clk);
    end
    chk("t5_req_cycles", cnt, 32'd4);
    chk("t5_state", 32'(state), 32'd3);
    chk("t5_bus_err", 32'(bus_err), 32'd1);
    retire = 1'b1; ls_req = 1'b1;
    repeat (3) @(negedge clk);
    retire = 1'b0; ls_req = 1'b0;
    chk("t5_halt_stays", 32'(state), 32'd3);
    chk("t5_err_sticky", 32'(bus_err), 32'd1);
    chk("t5_req_low", 32'(mem_req), 32'd0);
    no_ack = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_err", 32'(bus_err), 32'd0);
    ack_delay = 3;
    start_after_reset();
    op_ls(1'b0, 16'h0040, 16'h0, 1'b0);
    chk("t5_ack4_err", 32'(bus_err), 32'd0);
    chk("t5_ack4_state", 32'(state), 32'd1);

    // 6: reset during a pending load
    no_ack = 1'b1;
    req_q.push_back('{we: 1'b0, addr: 16'h0048, wdata: 16'h0});
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0048;
    @(negedge clk);
    ls_req = 1'b0;
    @(negedge clk);
    chk("t6_req_pending", 32'(mem_req), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_req", 32'(mem_req), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_ls_done", 32'(ls_done), 32'd0);
    no_ack = 1'b0;
    ack_delay = 0;
    start_after_reset();
    repeat (5) @(negedge clk);
    chk("end_queues_empty", 32'(req_q.size() + evt_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
